doc_audio_mixer: RTL and testbench
==================================

Name: doc_audio_mixer

Overview:
- Downstream stage of the DOC (Ensoniq sound-chip) core.
- Consumes one signed, volume-scaled sample per running oscillator, each tagged with its 4-bit channel-assignment nibble.
- Sums the samples into left/right accumulators over one full oscillator scan (frame), then presents a saturated 16-bit stereo pair to the audio output path through a valid/ready handshake.

Parameters:
- ACC_W, 22: accumulator width in bits, signed; holds 32 worst-case samples without overflow.
- SHIFT, 3: arithmetic right shift applied to each frame sum before saturation (headroom attenuation).
- MONO, 0: when 1, every sample goes to both accumulators regardless of channel.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- smp_valid  in  1  one-cycle strobe: smp_data/smp_ca valid this cycle
- smp_data  in  16  signed two's-complement oscillator sample
- smp_ca  in  4  channel assignment of the sample
- frame_end  in  1  one-cycle strobe: oscillator scan complete
- out_valid  out  1  stereo pair available
- out_ready  in  1  consumer accepts pair when out_valid && out_ready
- out_left  out  16  signed left sample
- out_right  out  16  signed right sample
- overrun  out  1  sticky: a completed frame replaced an unconsumed pair
- clr_overrun  in  1  clears overrun

Behaviour:
- Reset: acc_l and acc_r = 0; out_valid, out_left, out_right and overrun = 0; sample counter = 0.
- Routing:
  - MONO=0: smp_ca[0]==0 adds to acc_l; smp_ca[0]==1 adds to acc_r. smp_ca[3:1] is ignored.
  - MONO=1: every sample adds to both accumulators.
- Accumulation:
  - smp_data is sign-extended to ACC_W, then added to the selected accumulator on a smp_valid cycle.
  - Accumulator wrap is not prevented. ACC_W must be at least 21.
- Frame close, on a frame_end cycle:
  - A smp_valid in the same cycle is included in the closing frame: the closed sum is acc + sample.
  - Each closed sum is arithmetically shifted right by SHIFT, then clamped to the range [-32768, 32767].
  - The clamped values load out_left/out_right on the next clock edge. out_valid rises on that same edge, giving 1-cycle latency from frame_end.
  - Both accumulators restart on that edge at 0, or at none of the sample if no smp_valid accompanied frame_end. A sample never both closes one frame and seeds the next.
- Frame with no samples: produces a 0/0 pair with out_valid asserted.
- Handshake:
  - The pair and out_valid hold stable until out_valid && out_ready.
  - On acceptance, out_valid drops the next cycle unless a frame closes in that same cycle.
  - Frame close while out_valid=1 and out_ready=0: the new pair overwrites the old one, out_valid stays 1, and overrun is set.
  - Frame close in the same cycle as acceptance: the new pair loads, out_valid stays 1, and no overrun is flagged.
- overrun:
  - Sticky until clr_overrun or reset.
  - If set and clr_overrun occur in the same cycle, set wins.
- sample counter: 6-bit internal count of smp_valid per frame, cleared at frame close. It is debug-visible only.
- reset mid-frame: discards partial sums and any pending pair. No output pulse follows.

Test Plan:
- After reset, smp_valid with ca=0, data=0x0100; then ca=1, data=0xFF00; then frame_end -> 1 cycle later out_valid=1, out_left=0x0020, out_right=0xFFE0 (SHIFT=3).
- 32 samples of 0x7FFF all on ca=0, then frame_end -> out_left=0x7FFF (sum 0xFFFE0>>3=0x1FFFC, saturated), out_right=0x0000.
- 32 samples of 0x8000 on ca=1 -> out_right=0x8000 (saturated negative). With MONO=1, out_left is also 0x8000.
- Hold out_ready=0 across two frames (first left sum 0x0080, second 0x0100) -> out_left=0x0020 after the second close, overrun=1. clr_overrun -> overrun=0.
- smp_valid (ca=0, 0x0008) coincident with frame_end -> closing pair left=0x0001. The following empty frame yields left=0x0000.
- Assert reset after 5 samples of 0x1000 mid-frame -> out_valid stays 0. The next frame holding a single sample of 0x0040 yields 0x0008.

Source files
------------

// File: rtl/doc_audio_mixer.sv
// rtl/doc_audio_mixer.sv - DOC stereo mixer: per-frame L/R accumulation, shift, saturate, handshake out
//
// Purpose: sums the signed, volume-scaled oscillator samples of one oscillator scan
// into left/right accumulators. At frame_end it presents a shifted, saturated 16-bit
// stereo pair through a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   smp_valid    one-cycle strobe, smp_data/smp_ca valid
//   smp_data     signed 16-bit oscillator sample
//   smp_ca       channel-assignment nibble (bit 0 selects L/R)
//   frame_end    one-cycle strobe, oscillator scan complete
//   out_valid    stereo pair available
//   out_ready    consumer accepts pair when out_valid && out_ready
//   out_left     signed left sample
//   out_right    signed right sample
//   overrun      sticky, a frame replaced an unconsumed pair
//   clr_overrun  clears overrun (a simultaneous set wins)
module doc_audio_mixer #(
  parameter int ACC_W = 22,
  parameter int SHIFT = 3,
  parameter bit MONO  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  input  logic [3:0]  smp_ca,
  input  logic        frame_end,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
  output logic        overrun,
  input  logic        clr_overrun
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-15){1'b0}}, 15'h7FFF};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 15'h0000};

  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] smp_ext;
  logic signed [ACC_W-1:0] sum_l;
  logic signed [ACC_W-1:0] sum_r;
  logic signed [ACC_W-1:0] shr_l;
  logic signed [ACC_W-1:0] shr_r;
  logic                    add_l;
  logic                    add_r;
  logic                    accept;
  logic                    set_overrun;
  logic [5:0]              smp_cnt;
  logic                    unused_dbg;

  function automatic logic [15:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      saturate = 16'h7FFF;
    end else if (v < SAT_MIN) begin
      saturate = 16'h8000;
    end else begin
      saturate = v[15:0];
    end
  endfunction

  assign smp_ext = {{(ACC_W-16){smp_data[15]}}, smp_data};
  assign add_l   = smp_valid && (MONO || !smp_ca[0]);
  assign add_r   = smp_valid && (MONO ||  smp_ca[0]);

  // Running sums including this cycle's sample; these are also the closed sums,
  // so a sample coincident with frame_end lands in the closing frame.
  assign sum_l = acc_l + (add_l ? smp_ext : '0);
  assign sum_r = acc_r + (add_r ? smp_ext : '0);
  assign shr_l = sum_l >>> SHIFT;
  assign shr_r = sum_r >>> SHIFT;

  assign accept      = out_valid && out_ready;
  assign set_overrun = frame_end && out_valid && !out_ready;

  // Sample count and ignored channel bits are kept for debug visibility only.
  assign unused_dbg = ^{smp_ca[3:1], smp_cnt};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_l     <= '0;
      acc_r     <= '0;
      smp_cnt   <= '0;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= set_overrun || (overrun && !clr_overrun);
      if (frame_end) begin
        acc_l     <= '0;
        acc_r     <= '0;
        smp_cnt   <= '0;
        out_left  <= saturate(shr_l);
        out_right <= saturate(shr_r);
        out_valid <= 1'b1;
      end else begin
        acc_l   <= sum_l;
        acc_r   <= sum_r;
        smp_cnt <= smp_cnt + {5'b0, smp_valid};
        if (accept) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_doc_audio_mixer.sv
// tb/tb_doc_audio_mixer.sv - directed self-checking bench for doc_audio_mixer (stereo and mono instances)
module tb_doc_audio_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic [3:0]  smp_ca;
  logic        frame_end;
  logic        out_ready;
  logic        clr_overrun;

  logic        out_valid;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        overrun;

  logic        m_out_valid;
  logic [15:0] m_out_left;
  logic [15:0] m_out_right;
  logic        m_overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  doc_audio_mixer #(.ACC_W(22), .SHIFT(3), .MONO(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ca      (smp_ca),
    .frame_end   (frame_end),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_left    (out_left),
    .out_right   (out_right),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  doc_audio_mixer #(.ACC_W(22), .SHIFT(3), .MONO(1'b1)) dut_mono (
    .clk         (clk),
    .reset       (reset),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ca      (smp_ca),
    .frame_end   (frame_end),
    .out_valid   (m_out_valid),
    .out_ready   (out_ready),
    .out_left    (m_out_left),
    .out_right   (m_out_right),
    .overrun     (m_overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] ca, input logic [15:0] data);
    smp_valid = 1'b1;
    smp_ca    = ca;
    smp_data  = data;
    step();
    smp_valid = 1'b0;
  endtask

  task automatic close_frame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic accept_pair();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    smp_valid   = 1'b0;
    smp_data    = 16'h0000;
    smp_ca      = 4'h0;
    frame_end   = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_valid",   {15'b0, out_valid}, 16'h0000);
    chk("rst_left",    out_left,           16'h0000);
    chk("rst_right",   out_right,          16'h0000);
    chk("rst_overrun", {15'b0, overrun},   16'h0000);

    // Basic L/R routing, one cycle latency, then hold and accept.
    send(4'h0, 16'h0100);
    send(4'h1, 16'hFF00);
    chk("pre_close_valid", {15'b0, out_valid}, 16'h0000);
    close_frame();
    chk("basic_valid", {15'b0, out_valid}, 16'h0001);
    chk("basic_left",  out_left,           16'h0020);
    chk("basic_right", out_right,          16'hFFE0);
    chk("mono_basic_left",  m_out_left,  16'h0000);
    chk("mono_basic_right", m_out_right, 16'h0000);
    step();
    chk("hold_valid", {15'b0, out_valid}, 16'h0001);
    chk("hold_left",  out_left,           16'h0020);
    accept_pair();
    chk("accept_drop", {15'b0, out_valid}, 16'h0000);

    // Positive saturation on the left.
    for (int i = 0; i < 32; i++) send(4'h0, 16'h7FFF);
    close_frame();
    chk("satp_left",  out_left,  16'h7FFF);
    chk("satp_right", out_right, 16'h0000);
    chk("mono_satp_left",  m_out_left,  16'h7FFF);
    chk("mono_satp_right", m_out_right, 16'h7FFF);
    accept_pair();

    // Negative saturation on the right; upper ca bits ignored.
    for (int i = 0; i < 32; i++) send(4'hF, 16'h8000);
    close_frame();
    chk("satn_left",  out_left,  16'h0000);
    chk("satn_right", out_right, 16'h8000);
    chk("mono_satn_left",  m_out_left,  16'h8000);
    chk("mono_satn_right", m_out_right, 16'h8000);
    accept_pair();

    // Overrun: two frames without acceptance.
    send(4'h0, 16'h0080);
    close_frame();
    chk("ovr1_left",    out_left,         16'h0010);
    chk("ovr1_overrun", {15'b0, overrun}, 16'h0000);
    send(4'h0, 16'h0100);
    close_frame();
    chk("ovr2_left",    out_left,           16'h0020);
    chk("ovr2_valid",   {15'b0, out_valid}, 16'h0001);
    chk("ovr2_overrun", {15'b0, overrun},   16'h0001);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clear", {15'b0, overrun}, 16'h0000);

    // Set and clear together: set wins; empty frame gives 0/0.
    frame_end   = 1'b1;
    clr_overrun = 1'b1;
    step();
    frame_end   = 1'b0;
    clr_overrun = 1'b0;
    chk("setwins_overrun", {15'b0, overrun}, 16'h0001);
    chk("empty_left",      out_left,         16'h0000);
    chk("empty_right",     out_right,        16'h0000);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("setwins_clear", {15'b0, overrun}, 16'h0000);

    // Frame close coincident with acceptance: new pair, no overrun.
    send(4'h0, 16'h0040);
    out_ready = 1'b1;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    chk("acc_close_valid",   {15'b0, out_valid}, 16'h0001);
    chk("acc_close_left",    out_left,           16'h0008);
    chk("acc_close_overrun", {15'b0, overrun},   16'h0000);
    step();
    out_ready = 1'b0;
    chk("acc_close_drop", {15'b0, out_valid}, 16'h0000);

    // Sample coincident with frame_end belongs to the closing frame only.
    smp_valid = 1'b1;
    smp_ca    = 4'h0;
    smp_data  = 16'h0008;
    frame_end = 1'b1;
    step();
    smp_valid = 1'b0;
    frame_end = 1'b0;
    chk("coinc_left", out_left, 16'h0001);
    accept_pair();
    close_frame();
    chk("coinc_next_valid", {15'b0, out_valid}, 16'h0001);
    chk("coinc_next_left",  out_left,           16'h0000);
    accept_pair();

    // Reset mid-frame with a pending pair and an overrun flag.
    send(4'h0, 16'h0200);
    close_frame();
    send(4'h0, 16'h0200);
    close_frame();
    chk("pend_left",    out_left,         16'h0040);
    chk("pend_overrun", {15'b0, overrun}, 16'h0001);
    for (int i = 0; i < 5; i++) send(4'h0, 16'h1000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid",   {15'b0, out_valid}, 16'h0000);
    chk("midrst_left",    out_left,           16'h0000);
    chk("midrst_overrun", {15'b0, overrun},   16'h0000);
    step();
    step();
    chk("midrst_no_pulse", {15'b0, out_valid}, 16'h0000);
    send(4'h0, 16'h0040);
    close_frame();
    chk("post_rst_valid", {15'b0, out_valid}, 16'h0001);
    chk("post_rst_left",  out_left,           16'h0008);
    chk("post_rst_right", out_right,          16'h0000);
    chk("mono_post_rst_right", m_out_right,   16'h0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
